// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: drives the PC register controls and the instruction-memory port,
// holds each fetched word for decode and buffers redirects raised while a fetch is stalled.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_BOOT  | load RESET_VEC into the PC register
// S_IDLE  | no fetch outstanding; apply any redirect, start when run=1
// S_FETCH | imem_req held at pc_in until imem_ack or timeout
// S_ISSUE | instr valid, waiting for decode (or flushed by a redirect)
// S_HALT  | fetch timed out; only rstB leaves
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic        clk,
    input  logic        rstB,
    input  logic        run,
    input  logic [31:0] pc_in,
    output logic        pc_clkEn,
    output logic        pc_condEn,
    output logic [31:0] pc_next,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    input  logic        instr_ready,
    input  logic        redir_valid,
    input  logic [31:0] redir_pc,
    input  logic        trap_valid,
    input  logic [31:0] trap_vec,
    output logic        fetch_timeout
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TC_LOAD = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_BOOT,
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_HALT
    } state_t;

    state_t state, state_nxt;

    logic          pend_v;
    logic          pend_trap;
    logic [31:0]   pend_addr;
    logic [CW-1:0] wait_cnt;

    logic        eff_v;
    logic [31:0] eff_addr;
    logic        consume;
    logic        load_instr;
    logic        clr_valid;
    logic        cnt_load;
    logic        cnt_dec;
    logic        set_timeout;

    // A trap arriving this cycle beats a redirect arriving this cycle, which beats anything pended.
    always_comb begin
        eff_v = trap_valid | redir_valid | pend_v;
        if (trap_valid) begin
            eff_addr = trap_vec;
        end else if (redir_valid) begin
            eff_addr = redir_pc;
        end else begin
            eff_addr = pend_addr;
        end
    end

    always_comb begin
        state_nxt   = state;
        pc_clkEn    = 1'b0;
        pc_condEn   = 1'b0;
        pc_next     = 32'h0;
        consume     = 1'b0;
        load_instr  = 1'b0;
        clr_valid   = 1'b0;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;
        set_timeout = 1'b0;

        case (state)
            S_BOOT: begin
                pc_clkEn  = 1'b1;
                pc_condEn = 1'b1;
                pc_next   = RESET_VEC;
                state_nxt = S_IDLE;
            end

            S_IDLE: begin
                consume = eff_v;
                if (run) begin
                    state_nxt = S_FETCH;
                    cnt_load  = 1'b1;
                end
            end

            S_FETCH: begin
                if (imem_ack) begin
                    if (eff_v) begin
                        // The returned word belongs to the old path; drop it and refetch.
                        consume   = 1'b1;
                        cnt_load  = 1'b1;
                        state_nxt = run ? S_FETCH : S_IDLE;
                    end else begin
                        load_instr = 1'b1;
                        state_nxt  = S_ISSUE;
                    end
                end else if (wait_cnt == '0) begin
                    set_timeout = 1'b1;
                    state_nxt   = S_HALT;
                end else begin
                    cnt_dec = 1'b1;
                end
            end

            S_ISSUE: begin
                if (eff_v) begin
                    consume   = 1'b1;
                    clr_valid = 1'b1;
                    cnt_load  = 1'b1;
                    state_nxt = run ? S_FETCH : S_IDLE;
                end else if (instr_ready) begin
                    pc_clkEn  = 1'b1;
                    clr_valid = 1'b1;
                    cnt_load  = 1'b1;
                    state_nxt = run ? S_FETCH : S_IDLE;
                end
            end

            S_HALT: begin
                state_nxt = S_HALT;
            end

            default: begin
                state_nxt = S_BOOT;
            end
        endcase

        if (consume) begin
            pc_clkEn  = 1'b1;
            pc_condEn = 1'b1;
            pc_next   = eff_addr & 32'hFFFF_FFFC;
        end
    end

    assign imem_req  = (state == S_FETCH);
    assign imem_addr = pc_in;

    always_ff @(posedge clk or negedge rstB) begin
        if (!rstB) begin
            state <= S_BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rstB) begin
        if (!rstB) begin
            pend_v    <= 1'b0;
            pend_trap <= 1'b0;
            pend_addr <= 32'h0;
        end else if (consume) begin
            pend_v    <= 1'b0;
            pend_trap <= 1'b0;
        end else if (trap_valid) begin
            pend_v    <= 1'b1;
            pend_trap <= 1'b1;
            pend_addr <= trap_vec;
        end else if (redir_valid && !(pend_v && pend_trap)) begin
            pend_v    <= 1'b1;
            pend_trap <= 1'b0;
            pend_addr <= redir_pc;
        end
    end

    always_ff @(posedge clk or negedge rstB) begin
        if (!rstB) begin
            wait_cnt <= '0;
        end else if (cnt_load) begin
            wait_cnt <= TC_LOAD;
        end else if (cnt_dec) begin
            wait_cnt <= wait_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstB) begin
        if (!rstB) begin
            instr_valid   <= 1'b0;
            instr         <= 32'h0;
            fetch_timeout <= 1'b0;
        end else begin
            if (load_instr) begin
                instr_valid <= 1'b1;
                instr       <= imem_rdata;
            end else if (clr_valid) begin
                instr_valid <= 1'b0;
            end
            if (set_timeout) begin
                fetch_timeout <= 1'b1;
            end
        end
    end

endmodule
